// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - instruction-memory, redirect and decode signal bundle for fetch_decode
//
// master: the fetch stage side (drives requests and the decode outputs).
// slave : the environment side (instruction memory, branch unit, decode consumer).
//
//   imem_req_valid/imem_req_ready/imem_addr  fetch request channel
//   imem_resp_valid/imem_resp_data           in-order instruction responses
//   redirect_valid/redirect_pc               flush and restart fetch
//   dec_valid/dec_ready                      decoded-instruction handshake
//   dec_pc/dec_opcode/dec_rd/dec_rs1/dec_rs2/dec_imm  decoded fields of the FIFO head

interface fetch_decode_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [14:0] dec_imm;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_pc,
        output dec_opcode,
        output dec_rd,
        output dec_rs1,
        output dec_rs2,
        output dec_imm
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_pc,
        input  dec_opcode,
        input  dec_rd,
        input  dec_rs1,
        input  dec_rs2,
        input  dec_imm
    );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch with credit-limited requests, FIFO buffering and field split
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_decode_if.master: imem request/response channel, redirect, decode outputs
//
// Parameters:
//   PC_RESET - fetch address after reset
//   DEPTH    - FIFO entries; also the bound on FIFO occupancy + outstanding requests

module fetch_decode #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst,
    fetch_decode_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      head_pc_q, head_pc_d;
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W:0]   credit_used;
    logic             req_valid;
    logic             req_fire;
    logic             dec_valid;
    logic             fifo_wr;
    logic             fifo_pop;
    logic             resp_drop;
    logic [31:0]      head_w;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Outstanding requests reserve a FIFO slot, so a response can always be stored.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    assign req_valid   = !rst && !bus.redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign dec_valid   = (count_q != '0);

    // Responses for requests issued before a redirect are drained without storing.
    assign resp_drop = bus.imem_resp_valid && (drop_q != '0);
    assign fifo_wr   = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
    assign fifo_pop  = dec_valid && bus.dec_ready && !bus.redirect_valid;

    assign head_w = mem_q[rd_ptr_q];

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.dec_valid      = dec_valid;
    assign bus.dec_pc         = head_pc_q;
    assign bus.dec_opcode     = head_w[31:25];
    assign bus.dec_rd         = head_w[24:20];
    assign bus.dec_rs1        = head_w[19:15];
    assign bus.dec_rs2        = head_w[14:10];
    assign bus.dec_imm        = head_w[14:0];

    always_comb begin
        pc_d      = pc_q;
        head_pc_d = head_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        outst_d   = outst_q;
        drop_d    = drop_q;

        if (bus.redirect_valid) begin
            pc_d      = bus.redirect_pc;
            head_pc_d = bus.redirect_pc;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            // No request issues this cycle; every request still in flight
            // after this cycle's response belongs to the old path.
            outst_d   = outst_q - CNT_W'(bus.imem_resp_valid);
            drop_d    = outst_q - CNT_W'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);
            if (resp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (fifo_wr) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_d  = next_ptr(rd_ptr_q);
                head_pc_d = head_pc_q + 32'd4;
            end
            count_d = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= PC_RESET;
            head_pc_q <= PC_RESET;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            head_pc_q <= head_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= bus.imem_resp_data;
            end
            // A stored response into a full FIFO means the credit rule was broken.
            assert (!(bus.imem_resp_valid && (drop_q == '0) && (count_q == CNT_W'(DEPTH))));
        end
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed table-driven bench for fetch_decode

module tb_fetch_decode;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [14:0] imm;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [14:0] imm;
    } pop_t;

    logic clk;
    logic rst;
    fetch_decode_if bus ();

    fetch_decode #(.PC_RESET(PC_RESET), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t        vec [8];
    pop_t        popped [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_addr;

    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_dec_valid;
    logic [31:0] s_dec_pc;
    logic [6:0]  s_opc;
    logic [4:0]  s_rd;
    logic [4:0]  s_rs1;
    logic [4:0]  s_rs2;
    logic [14:0] s_imm;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd32) begin
            return vec[a[4:2]].instr;
        end
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, score handshakes, then
    // advance the memory model just after the rising edge.
    task automatic tick();
        logic        acc;
        logic        pop;
        logic        resp_taken;
        logic [31:0] w;
        pop_t        p;
        @(negedge clk);
        s_req_valid = bus.imem_req_valid;
        s_addr      = bus.imem_addr;
        s_dec_valid = bus.dec_valid;
        s_dec_pc    = bus.dec_pc;
        s_opc       = bus.dec_opcode;
        s_rd        = bus.dec_rd;
        s_rs1       = bus.dec_rs1;
        s_rs2       = bus.dec_rs2;
        s_imm       = bus.dec_imm;
        acc         = bus.imem_req_valid && bus.imem_req_ready;
        pop         = bus.dec_valid && bus.dec_ready && !bus.redirect_valid && !rst;
        resp_taken  = bus.imem_resp_valid;
        if (acc === 1'b1) begin
            chk("req_addr", s_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (pop === 1'b1) begin
            w = word_at(exp_pc);
            chk("pop_pc", s_dec_pc, exp_pc);
            chk("pop_word", {s_opc, s_rd, s_rs1, s_imm}, w);
            chk("pop_rs2", {27'd0, s_rs2}, {27'd0, w[14:10]});
            p.pc = s_dec_pc; p.opc = s_opc; p.rd = s_rd; p.rs1 = s_rs1; p.rs2 = s_rs2; p.imm = s_imm;
            popped.push_back(p);
            exp_pc = exp_pc + 32'd4;
        end
        if (bus.redirect_valid && !rst) begin
            exp_pc       = bus.redirect_pc;
            exp_req_addr = bus.redirect_pc;
        end
        if (rst) begin
            exp_pc       = PC_RESET;
            exp_req_addr = PC_RESET;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (resp_taken && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (acc === 1'b1) begin
                pend_addr.push_back(s_addr);
                pend_due.push_back(cyc - 1 + lat);
            end
        end
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = word_at(pend_addr[0]);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (popped.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (popped.size() < n) begin
            n_fail++;
            $display("FAIL %s: timeout, got %0d pops, expected %0d", name, popped.size(), n);
        end
    endtask

    task automatic chk_pop_pc(input int idx, input logic [31:0] exp, input string name);
        if (popped.size() > idx) begin
            chk(name, popped[idx].pc, exp);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: pop %0d missing, expected pc 0x%08h", name, idx, exp);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] h_pc;
        logic [31:0] h_w;
        logic        prev_stalled;
        logic [31:0] prev_addr;

        vec[0] = '{32'h0A14_7FFF, 7'h05, 5'h01, 5'h08, 5'h1F, 15'h7FFF};
        vec[1] = '{32'hFFFF_FFFF, 7'h7F, 5'h1F, 5'h1F, 5'h1F, 15'h7FFF};
        vec[2] = '{32'h0000_0000, 7'h00, 5'h00, 5'h00, 5'h00, 15'h0000};
        vec[3] = '{32'h8000_0000, 7'h40, 5'h00, 5'h00, 5'h00, 15'h0000};
        vec[4] = '{32'h01F0_0000, 7'h00, 5'h1F, 5'h00, 5'h00, 15'h0000};
        vec[5] = '{32'h000F_8000, 7'h00, 5'h00, 5'h1F, 5'h00, 15'h0000};
        vec[6] = '{32'h0000_7C00, 7'h00, 5'h00, 5'h00, 5'h1F, 15'h7C00};
        vec[7] = '{32'h1234_5678, 7'h09, 5'h03, 5'h08, 5'h15, 15'h5678};

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;
        exp_pc       = PC_RESET;
        exp_req_addr = PC_RESET;
        rst                 = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.dec_ready       = 1'b1;

        // Reset state
        do_reset();
        chk("rst_req_valid", {31'd0, s_req_valid}, 32'd0);
        chk("rst_dec_valid", {31'd0, s_dec_valid}, 32'd0);
        chk("rst_addr", s_addr, PC_RESET);
        chk("rst_dec_pc", s_dec_pc, PC_RESET);
        chk("rst_fields", {s_opc, s_rd, s_rs1, s_imm}, 32'd0);
        chk("rst_rs2", {27'd0, s_rs2}, 32'd0);

        // First-fetch latency, then the decode table streamed from 0x0
        tick();
        chk("c0_req_valid", {31'd0, s_req_valid}, 32'd1);
        chk("c0_addr", s_addr, 32'h0);
        tick();
        chk("c1_dec_valid", {31'd0, s_dec_valid}, 32'd0);
        chk("c1_addr", s_addr, 32'h4);
        tick();
        chk("c2_dec_valid", {31'd0, s_dec_valid}, 32'd1);
        chk("c2_dec_pc", s_dec_pc, 32'h0);
        wait_pops(8, 100, "table_stream");
        for (int i = 0; i < 8; i++) begin
            if (popped.size() > i) begin
                chk($sformatf("tbl%0d_pc", i), popped[i].pc, 32'(i * 4));
                chk($sformatf("tbl%0d_opc", i), {25'd0, popped[i].opc}, {25'd0, vec[i].opc});
                chk($sformatf("tbl%0d_rd", i), {27'd0, popped[i].rd}, {27'd0, vec[i].rd});
                chk($sformatf("tbl%0d_rs1", i), {27'd0, popped[i].rs1}, {27'd0, vec[i].rs1});
                chk($sformatf("tbl%0d_rs2", i), {27'd0, popped[i].rs2}, {27'd0, vec[i].rs2});
                chk($sformatf("tbl%0d_imm", i), {17'd0, popped[i].imm}, {17'd0, vec[i].imm});
            end
        end

        // Back-pressure: FIFO fills, requests stop, head held stable
        bus.dec_ready = 1'b0;
        tick();
        tick();
        tick();
        h_pc = s_dec_pc;
        h_w  = {s_opc, s_rd, s_rs1, s_imm};
        chk("stall_req_valid", {31'd0, s_req_valid}, 32'd0);
        chk("stall_dec_valid", {31'd0, s_dec_valid}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_req_hold", {31'd0, s_req_valid}, 32'd0);
            chk("stall_pc_hold", s_dec_pc, h_pc);
            chk("stall_word_hold", {s_opc, s_rd, s_rs1, s_imm}, h_w);
        end
        bus.dec_ready = 1'b1;
        n = popped.size();
        wait_pops(n + 4, 40, "stall_release");
        chk_pop_pc(n, h_pc, "stall_next_pc");

        // Redirect with two requests outstanding at 3-cycle latency
        do_reset();
        lat = 3;
        tick();
        tick();
        chk("redir_outstanding", 32'(pend_addr.size()), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        chk("redir_no_req", {31'd0, s_req_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        wait_pops(1, 40, "redir_first");
        chk_pop_pc(0, 32'h100, "redir_first_pc");

        // Redirect coinciding with a pop and an arriving response
        do_reset();
        lat = 1;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        chk("redir2_dec_valid_pre", {31'd0, s_dec_valid}, 32'd1);
        bus.redirect_valid = 1'b0;
        tick();
        chk("redir2_dec_valid_post", {31'd0, s_dec_valid}, 32'd0);
        chk("redir2_no_pop", 32'(popped.size()), 32'd0);
        wait_pops(1, 20, "redir2_first");
        chk_pop_pc(0, 32'h200, "redir2_first_pc");

        // Request ready toggling: address holds until accepted
        do_reset();
        prev_stalled = 1'b0;
        prev_addr    = '0;
        for (int i = 0; i < 16; i++) begin
            bus.imem_req_ready = (i % 2 == 0);
            tick();
            if (prev_stalled) begin
                chk("toggle_addr_hold", s_addr, prev_addr);
            end
            prev_stalled = s_req_valid && !bus.imem_req_ready;
            prev_addr    = s_addr;
        end
        bus.imem_req_ready = 1'b1;

        // PC wrap across 0xFFFF_FFFC
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        n = popped.size();
        wait_pops(n + 3, 40, "wrap_stream");
        chk_pop_pc(n, 32'hFFFF_FFF8, "wrap_pc0");
        chk_pop_pc(n + 1, 32'hFFFF_FFFC, "wrap_pc1");
        chk_pop_pc(n + 2, 32'h0000_0000, "wrap_pc2");

        // Reset in mid-stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        popped.delete();
        tick();
        chk("midrst_dec_valid", {31'd0, s_dec_valid}, 32'd0);
        chk("midrst_addr", s_addr, PC_RESET);
        chk("midrst_dec_pc", s_dec_pc, PC_RESET);
        wait_pops(1, 20, "midrst_first");
        chk_pop_pc(0, PC_RESET, "midrst_first_pc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
